// File: rtl/array_copy_seq.sv
// Sequenced ROWS x COLS array copy engine: src bank loaded via write port, copied to dst one element per cycle.
// Define ARRAY_COPY_VERIFY_EN to add a post-copy VERIFY walk and a sticky mismatch output.
module array_copy_seq #(
  parameter int ROWS = 2,
  parameter int COLS = 2,
  parameter int W    = 1,
  localparam int RB  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CB  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [RB-1:0] wr_row,
  input  logic [CB-1:0] wr_col,
  input  logic [W-1:0]  wr_data,
  input  logic          start,
  input  logic          rev,
  output logic          busy,
  output logic          done,
  input  logic [RB-1:0] rd_row,
  input  logic [CB-1:0] rd_col,
  output logic [W-1:0]  rd_data
`ifdef ARRAY_COPY_VERIFY_EN
  ,
  output logic          mismatch
`endif
);

`ifdef ARRAY_COPY_VERIFY_EN
  typedef enum logic [1:0] {IDLE, COPY, VERIFY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;
`endif

  // One extra bit so the bound itself is representable for power-of-2 sizes.
  localparam logic [RB:0] ROWS_N = (RB + 1)'(ROWS);
  localparam logic [CB:0] COLS_N = (CB + 1)'(COLS);

  logic [W-1:0]  src [ROWS][COLS];
  logic [W-1:0]  dst [ROWS][COLS];
  state_t        state_q;
  logic [RB-1:0] r;
  logic [CB-1:0] c;
  logic          rev_q;

  logic          last_elem;
  logic [CB-1:0] dst_col;
  logic          wr_ok;

  assign last_elem = (r == RB'(ROWS - 1)) && (c == CB'(COLS - 1));
  assign dst_col   = rev_q ? (CB'(COLS - 1) - c) : c;
  assign wr_ok     = wr_en && (state_q == IDLE) &&
                     ({1'b0, wr_row} < ROWS_N) && ({1'b0, wr_col} < COLS_N);

  always_comb begin
    rd_data = '0;
    if (({1'b0, rd_row} < ROWS_N) && ({1'b0, rd_col} < COLS_N))
      rd_data = dst[rd_row][rd_col];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      r       <= '0;
      c       <= '0;
      rev_q   <= 1'b0;
`ifdef ARRAY_COPY_VERIFY_EN
      mismatch <= 1'b0;
`endif
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          src[i][j] <= '0;
          dst[i][j] <= '0;
        end
      end
    end else begin
      if (wr_ok)
        src[wr_row][wr_col] <= wr_data;

      case (state_q)
        IDLE: begin
          if (start) begin
            rev_q   <= rev;
            r       <= '0;
            c       <= '0;
            busy    <= 1'b1;
            state_q <= COPY;
`ifdef ARRAY_COPY_VERIFY_EN
            mismatch <= 1'b0;
`endif
          end
        end

        COPY: begin
          dst[r][dst_col] <= src[r][c];
          if (last_elem) begin
            r <= '0;
            c <= '0;
`ifdef ARRAY_COPY_VERIFY_EN
            state_q <= VERIFY;
`else
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
`endif
          end else if (c == CB'(COLS - 1)) begin
            c <= '0;
            r <= r + RB'(1);
          end else begin
            c <= c + CB'(1);
          end
        end

`ifdef ARRAY_COPY_VERIFY_EN
        VERIFY: begin
          if (dst[r][dst_col] != src[r][c])
            mismatch <= 1'b1;
          assert (dst[r][dst_col] == src[r][c])
            else $error("array_copy_seq: verify difference at row %0d col %0d", r, c);
          if (last_elem) begin
            r       <= '0;
            c       <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end else if (c == CB'(COLS - 1)) begin
            c <= '0;
            r <= r + RB'(1);
          end else begin
            c <= c + CB'(1);
          end
        end
`endif

        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_copy_seq.sv
// Bench for array_copy_seq: a 2x2 W=1 instance (a) and a 3x3 W=4 instance (b) against an index-arithmetic model.
module tb_array_copy_seq;

`ifdef ARRAY_COPY_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic [1:0]      wr_en_v = '0, start_v = '0, rev_v = '0;
  logic [1:0][1:0] wr_row_v = '0, wr_col_v = '0, rd_row_v = '0, rd_col_v = '0;
  logic [1:0][3:0] wr_data_v = '0;

  logic       busy_a, done_a, rd_data_a;
  logic       busy_b, done_b;
  logic [3:0] rd_data_b;
`ifdef ARRAY_COPY_VERIFY_EN
  logic       mism_a, mism_b;
`endif

  array_copy_seq #(.ROWS(2), .COLS(2), .W(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .wr_en(wr_en_v[0]), .wr_row(wr_row_v[0][0:0]), .wr_col(wr_col_v[0][0:0]), .wr_data(wr_data_v[0][0:0]),
    .start(start_v[0]), .rev(rev_v[0]), .busy(busy_a), .done(done_a),
    .rd_row(rd_row_v[0][0:0]), .rd_col(rd_col_v[0][0:0]), .rd_data(rd_data_a)
`ifdef ARRAY_COPY_VERIFY_EN
    , .mismatch(mism_a)
`endif
  );

  array_copy_seq #(.ROWS(3), .COLS(3), .W(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .wr_en(wr_en_v[1]), .wr_row(wr_row_v[1]), .wr_col(wr_col_v[1]), .wr_data(wr_data_v[1]),
    .start(start_v[1]), .rev(rev_v[1]), .busy(busy_b), .done(done_b),
    .rd_row(rd_row_v[1]), .rd_col(rd_col_v[1]), .rd_data(rd_data_b)
`ifdef ARRAY_COPY_VERIFY_EN
    , .mismatch(mism_b)
`endif
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: run position k counts elements 0..n-1 (copy) then n..2n-1 (verify).
  int src_m [2][3][3];
  int dst_m [2][3][3];
  int phase_m [2];
  int k_m [2];
  int rv_m [2];
  int mism_m [2];

  function automatic int dim_of(int d);  return d ? 3 : 2;  endfunction
  function automatic int imask(int d);   return d ? 3 : 1;  endfunction
  function automatic int dmask(int d);   return d ? 15 : 1; endfunction

  task automatic model_step(int d);
    int n, tot, e, r, c, dc, wr, wc;
    n   = dim_of(d) * dim_of(d);
    tot = VER ? 2 * n : n;
    if (rst) begin
      foreach (src_m[d][i, j]) begin
        src_m[d][i][j] = 0;
        dst_m[d][i][j] = 0;
      end
      phase_m[d] = 0; k_m[d] = 0; rv_m[d] = 0; mism_m[d] = 0;
      return;
    end
    case (phase_m[d])
      0: begin
        wr = int'(wr_row_v[d]) & imask(d);
        wc = int'(wr_col_v[d]) & imask(d);
        if (wr_en_v[d] && wr < dim_of(d) && wc < dim_of(d))
          src_m[d][wr][wc] = int'(wr_data_v[d]) & dmask(d);
        if (start_v[d]) begin
          rv_m[d] = rev_v[d]; k_m[d] = 0; phase_m[d] = 1; mism_m[d] = 0;
        end
      end
      1: begin
        e  = k_m[d] % n;
        r  = e / dim_of(d);
        c  = e % dim_of(d);
        dc = rv_m[d] ? dim_of(d) - 1 - c : c;
        if (k_m[d] < n) dst_m[d][r][dc] = src_m[d][r][c];
        else if (dst_m[d][r][dc] != src_m[d][r][c]) mism_m[d] = 1;
        k_m[d]++;
        if (k_m[d] == tot) phase_m[d] = 2;
      end
      default: phase_m[d] = 0;
    endcase
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int ra, ca, rb, cb;
      ra = int'(rd_row_v[0][0]); ca = int'(rd_col_v[0][0]);
      rb = int'(rd_row_v[1]);    cb = int'(rd_col_v[1]);
      check("busy_a", busy_a, phase_m[0] == 1);
      check("done_a", done_a, phase_m[0] == 2);
      check("rd_a", rd_data_a, dst_m[0][ra][ca]);
      check("busy_b", busy_b, phase_m[1] == 1);
      check("done_b", done_b, phase_m[1] == 2);
      check("rd_b", rd_data_b, (rb < 3 && cb < 3) ? dst_m[1][rb][cb] : 0);
`ifdef ARRAY_COPY_VERIFY_EN
      check("mism_a", mism_a, mism_m[0]);
      check("mism_b", mism_b, mism_m[1]);
`endif
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(int d, int r, int c, int v);
    wr_en_v[d] = 1'b1; wr_row_v[d] = 2'(r); wr_col_v[d] = 2'(c); wr_data_v[d] = 4'(v);
    cyc(1);
    wr_en_v[d] = 1'b0;
  endtask

  task automatic go(int d, bit rv);
    start_v[d] = 1'b1; rev_v[d] = rv;
    cyc(1);
    start_v[d] = 1'b0;
  endtask

  function automatic logic dn(int d);
    return d ? done_b : done_a;
  endfunction

  // Called right after the start edge; returns the cycle number in which done is seen.
  task automatic wait_done(int d, input string name, int exp_lat);
    int n;
    n = 1;
    while (!dn(d) && n < 64) begin
      cyc(1);
      n++;
    end
    check(name, n, exp_lat);
    cyc(1);
  endtask

  task automatic rd(int d, int r, int c, int exp, input string name);
    rd_row_v[d] = 2'(r); rd_col_v[d] = 2'(c);
    #1;
    check(name, d ? rd_data_b : 32'(rd_data_a), exp);
  endtask

  task automatic load_a();
    wr(0, 0, 0, 0); wr(0, 0, 1, 1); wr(0, 1, 0, 1); wr(0, 1, 1, 1);
  endtask

  initial begin
    int ndone;
    cyc(1);
    chk_on = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_busy_b", busy_b, 0);
    rd(0, 1, 1, 0, "rst_dst_a");

    // Straight and reversed copies on the 2x2 instance.
    load_a();
    go(0, 1'b0);
    wait_done(0, "lat_straight", VER ? 9 : 5);
    rd(0, 0, 0, 0, "str_00"); rd(0, 0, 1, 1, "str_01");
    rd(0, 1, 0, 1, "str_10"); rd(0, 1, 1, 1, "str_11");
    go(0, 1'b1);
    wait_done(0, "lat_rev", VER ? 9 : 5);
    rd(0, 0, 1, 0, "rev_01"); rd(0, 0, 0, 1, "rev_00");
    rd(0, 1, 1, 1, "rev_11"); rd(0, 1, 0, 1, "rev_10");

    // Starts and a source write while busy are ignored.
    go(0, 1'b0);
    start_v[0] = 1'b1;
    cyc(1);
    wr_en_v[0] = 1'b1; wr_row_v[0] = 2'd1; wr_col_v[0] = 2'd1; wr_data_v[0] = 4'd0;
    cyc(1);
    start_v[0] = 1'b0; wr_en_v[0] = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done_a) ndone++;
      cyc(1);
    end
    check("coll_done_count", ndone, 1);
    rd(0, 1, 1, 1, "coll_dst_11");
    go(0, 1'b0);
    wait_done(0, "lat_recopy", VER ? 9 : 5);
    rd(0, 1, 1, 1, "coll_src_11");

    // Reset in the middle of a run.
    go(0, 1'b0);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_done", done_a, 0);
    rd(0, 0, 1, 0, "mid_rst_01"); rd(0, 1, 1, 0, "mid_rst_11");
    load_a();
    go(0, 1'b0);
    wait_done(0, "lat_after_rst", VER ? 9 : 5);
    rd(0, 1, 0, 1, "after_rst_10");

    // Write and start in the same idle cycle: the run sees the new value.
    wr_en_v[0] = 1'b1; wr_row_v[0] = 2'd0; wr_col_v[0] = 2'd0; wr_data_v[0] = 4'd1;
    go(0, 1'b0);
    wr_en_v[0] = 1'b0;
    wait_done(0, "lat_wr_start", VER ? 9 : 5);
    rd(0, 0, 0, 1, "wr_start_00");

    // 3x3 W=4 reversed copy, plus out-of-range writes and reads.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        wr(1, r, c, 3 * r + c);
    wr(1, 3, 0, 9);
    wr(1, 0, 3, 9);
    go(1, 1'b1);
    wait_done(1, "lat_3x3", VER ? 19 : 10);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        rd(1, r, 2 - c, 3 * r + c, "dst_3x3");
    rd(1, 3, 0, 0, "oor_row");
    rd(1, 0, 3, 0, "oor_col");

    // Random traffic on both instances against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        wr_en_v[d]   = 1'($urandom_range(0, 1));
        wr_row_v[d]  = 2'($urandom_range(0, 3));
        wr_col_v[d]  = 2'($urandom_range(0, 3));
        wr_data_v[d] = 4'($urandom_range(0, 15));
        start_v[d]   = ($urandom_range(0, 7) == 0);
        rev_v[d]     = 1'($urandom_range(0, 1));
        rd_row_v[d]  = 2'($urandom_range(0, 3));
        rd_col_v[d]  = 2'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 1'b0; wr_en_v = '0; start_v = '0;
    cyc(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
